fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 68 ++++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   FETCH_XLEN    - default instruction/PC width
//   NOP_INSTR     - instruction presented when no valid entry is available
//   fetch_entry_t - queue entry {pc, instr} at the default width
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (pointers/count only)
//   flush       - empties the queue at the next edge (same effect as rst)
//   push, push_data - write an entry (ignored when full)
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry (undefined while empty)
//   full, empty, count - occupancy status
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  QDEPTH  = 2,
  localparam int CW      = $clog2(QDEPTH + 1),
  localparam int PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t          store [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            pop_ok;

  // Pointer wrap is explicit so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(QDEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC generator, on-chip instruction memory and an output
// queue with valid/ready handshake.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   redirect_valid/_pc        - branch/jump redirect (flushes pending fetches)
//   imem_we/_waddr/_wdata     - program-load write port (byte address)
//   out_valid/_ready          - output handshake
//   out_instr, out_pc         - head instruction and its byte address
//   misalign_err              - one-cycle flag for a misaligned redirect target
// Build option: define FETCH_ALIGN_CHECK_EN to enable misalign_err; otherwise
// it is tied low. In both builds the low two target bits are dropped.
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               XLEN        = FETCH_XLEN,
  parameter int               DEPTH_WORDS = 256,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int               QDEPTH      = 2,
  parameter string            INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            imem_we,
  input  logic [XLEN-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [31:0]     imem [DEPTH_WORDS];
  logic [XLEN-1:0] fetch_pc_p0;
  logic            vld_p0;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] redir_tgt;
  entry_t          push_data;
  entry_t          head;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic            pop;
  logic            unused_bits;

  assign rd_idx    = fetch_pc_p0[AW+1:2];
  assign wr_idx    = imem_waddr[AW+1:2];
  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // p0: issue. A read goes out whenever the queue has room and no redirect
  // is pending this cycle; the queue entry itself is the read register, so
  // the data appears at the output one cycle after issue.
  assign vld_p0 = !rst && !redirect_valid && !q_full;

  always_comb begin
    push_data       = '0;
    push_data.pc    = fetch_pc_p0;
    push_data.instr = imem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= redir_tgt;
    end else if (vld_p0) begin
      fetch_pc_p0 <= fetch_pc_p0 + XLEN'(4);
    end
  end

  // Write lands at the edge; a read issued in the same cycle sampled the
  // old word, and entries already queued keep what they captured.
  always_ff @(posedge clk) begin
    if (imem_we) imem[wr_idx] <= imem_wdata;
  end

  // p1: output queue. A redirect flushes everything, including the entry
  // that would otherwise be pushed this cycle.
  fetch_queue #(
    .entry_t (entry_t),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (vld_p0),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign out_valid = !q_empty && !rst;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head.pc    : '0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_p1 <= 1'b0;
    end else begin
      mis_p1 <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign misalign_err = mis_p1;
`else
  assign misalign_err = 1'b0;
`endif

  // Address bits outside the word index are intentionally ignored.
  assign unused_bits = ^{imem_waddr, redirect_pc[1:0], q_count};

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    bit          emis;
  } vec_t;

  vec_t tbl [29];

  // Program image loaded through the write port.
  function automatic logic [31:0] img(input int i);
    case (i)
      0: return 32'h0000_0011;
      1: return 32'h0000_0022;
      2: return 32'h0000_0033;
      3: return 32'h0000_0044;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  function automatic vec_t mk(bit r, bit rdy, bit rd, logic [31:0] rpc,
                              bit ev, logic [31:0] epc, logic [31:0] ei, bit em);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
    v.ev = ev; v.epc = ev ? epc : 32'h0; v.einstr = ev ? ei : NOP_INSTR; v.emis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ev, input logic [31:0] epc,
                         input logic [31:0] ei, input bit em);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, " out_pc"}, out_pc, ev ? epc : 32'h0);
    chk({tag, " out_instr"}, out_instr, ev ? ei : NOP_INSTR);
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'(em));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Startup / reset phase, streaming, back-pressure, redirects, wrap, misalign.
    tbl[0]  = mk(0, 1, 0, 0,      0, 0,       0,        0);
    tbl[1]  = mk(0, 1, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[2]  = mk(0, 1, 0, 0,      1, 32'h4,   img(1),   0);
    tbl[3]  = mk(0, 1, 0, 0,      1, 32'h8,   img(2),   0);
    tbl[4]  = mk(0, 1, 0, 0,      1, 32'hC,   img(3),   0);
    tbl[5]  = mk(1, 1, 0, 0,      0, 0,       0,        0);
    tbl[6]  = mk(0, 0, 0, 0,      0, 0,       0,        0);
    tbl[7]  = mk(0, 0, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[8]  = mk(0, 0, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[9]  = mk(0, 0, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[10] = mk(0, 0, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[11] = mk(0, 0, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[12] = mk(0, 1, 0, 0,      1, 32'h0,   img(0),   0);
    tbl[13] = mk(0, 1, 0, 0,      1, 32'h4,   img(1),   0);
    tbl[14] = mk(0, 1, 0, 0,      1, 32'h8,   img(2),   0);
    tbl[15] = mk(0, 1, 0, 0,      1, 32'hC,   img(3),   0);
    tbl[16] = mk(0, 0, 0, 0,      1, 32'h10,  img(4),   0);
    tbl[17] = mk(0, 0, 1, 32'h40, 1, 32'h10,  img(4),   0);
    tbl[18] = mk(0, 0, 0, 0,      0, 0,       0,        0);
    tbl[19] = mk(0, 1, 0, 0,      1, 32'h40,  img(16),  0);
    tbl[20] = mk(0, 1, 0, 0,      1, 32'h44,  img(17),  0);
    tbl[21] = mk(0, 1, 1, 32'h3FC,1, 32'h48,  img(18),  0);
    tbl[22] = mk(0, 1, 0, 0,      0, 0,       0,        0);
    tbl[23] = mk(0, 1, 0, 0,      1, 32'h3FC, img(255), 0);
    tbl[24] = mk(0, 1, 0, 0,      1, 32'h400, img(0),   0);
    tbl[25] = mk(0, 1, 1, 32'h22, 1, 32'h404, img(1),   0);
    tbl[26] = mk(0, 1, 0, 0,      0, 0,       0,        ALIGN_EN);
    tbl[27] = mk(0, 1, 0, 0,      1, 32'h20,  img(8),   0);
    tbl[28] = mk(0, 1, 0, 0,      1, 32'h24,  img(9),   0);

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; out_ready = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) begin
      imem_we = 1'b1; imem_waddr = 32'(i) << 2; imem_wdata = img(i);
      tick();
    end
    imem_we = 1'b0;
    #1;
    chk_out("reset", 0, 0, 0, 0);

    for (int r = 0; r < 29; r++) begin
      rst            = tbl[r].rst;
      out_ready      = tbl[r].rdy;
      redirect_valid = tbl[r].redir;
      redirect_pc    = tbl[r].rpc;
      #1;
      chk_out($sformatf("row%0d", r), tbl[r].ev, tbl[r].epc, tbl[r].einstr, tbl[r].emis);
      tick();
    end

    // Write then redirect to the written word: new data is fetched.
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h14;
    imem_we = 1'b1; imem_waddr = 32'h14; imem_wdata = 32'hDEAD_BEEF;
    #1; chk_out("wr_c1", 1, 32'h28, img(10), 0);
    tick();
    redirect_valid = 1'b0; imem_we = 1'b0;
    #1; chk_out("wr_c2", 0, 0, 0, 0);
    tick();
    #1; chk_out("wr_c3", 1, 32'h14, 32'hDEAD_BEEF, 0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    #1; chk_out("wr_c4", 1, 32'h18, img(6), 0);
    tick();
    // Write coinciding with the read of the same word: old data is fetched.
    redirect_valid = 1'b0; out_ready = 1'b0;
    imem_we = 1'b1; imem_waddr = 32'h18; imem_wdata = 32'hCAFE_F00D;
    #1; chk_out("wr_c5", 0, 0, 0, 0);
    tick();
    imem_we = 1'b0;
    #1; chk_out("wr_c6", 1, 32'h18, img(6), 0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    #1; chk_out("wr_c7", 1, 32'h18, img(6), 0);
    tick();
    redirect_valid = 1'b0;
    #1; chk_out("wr_c8", 0, 0, 0, 0);
    tick();
    #1; chk_out("wr_c9", 1, 32'h18, 32'hCAFE_F00D, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
